// File: rtl/gb_timer_pkg.sv
// Shared constants and types for the Game Boy DIV/TIMA timer block.
// Register offsets, the TAC tap table, overflow delay and FSM state type.
package gb_timer_pkg;

  localparam logic [1:0] ADR_DIV  = 2'd0;
  localparam logic [1:0] ADR_TIMA = 2'd1;
  localparam logic [1:0] ADR_TMA  = 2'd2;
  localparam logic [1:0] ADR_TAC  = 2'd3;

  localparam int TAP_00 = 9;
  localparam int TAP_01 = 3;
  localparam int TAP_10 = 5;
  localparam int TAP_11 = 7;

  localparam int         OVF_DELAY = 4;
  localparam logic [1:0] OVF_LAST  = 2'(OVF_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OVF,
    ST_RELOAD
  } ovfState_t;

  function automatic logic tapBit(input logic [15:0] cnt, input logic [1:0] sel);
    logic bitVal;
    case (sel)
      2'b00:   bitVal = cnt[TAP_00];
      2'b01:   bitVal = cnt[TAP_01];
      2'b10:   bitVal = cnt[TAP_10];
      default: bitVal = cnt[TAP_11];
    endcase
    return bitVal;
  endfunction

endpackage

// File: rtl/gb_timer_div.sv
// Free-running 16-bit divider with DIV clear, TAC tap mux and falling-edge tick detect.
// The tick is evaluated on next-state values so TIMA steps on the same edge the tap falls.
module gb_timer_div
  import gb_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_divClear,
  input  logic [2:0] i_tacNext,
  output logic [7:0] o_div,
  output logic       o_tickFall
);

  logic [15:0] r_cnt;
  logic        r_tickPrev;
  logic [15:0] w_cntNext;
  logic        w_tickNext;

  always_comb begin
    w_cntNext  = i_divClear ? 16'd0 : r_cnt + 16'd1;
    w_tickNext = i_tacNext[2] & tapBit(w_cntNext, i_tacNext[1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 16'd0;
      r_tickPrev <= 1'b0;
    end else begin
      r_cnt      <= w_cntNext;
      r_tickPrev <= w_tickNext;
    end
  end

  assign o_div      = r_cnt[15:8];
  assign o_tickFall = r_tickPrev & ~w_tickNext;

endmodule

// File: rtl/gb_timer.sv
// Game Boy timer: TIMA/TMA/TAC registers, delayed-overflow reload FSM and bus read mux.
module gb_timer
  import gb_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] adr,
  input  logic       sel_tim,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_tim
);

  logic [7:0] r_tima;
  logic [7:0] r_tma;
  logic [2:0] r_tac;
  ovfState_t  r_state;
  logic [1:0] r_ovfCnt;
  logic       r_irq;

  logic       w_wrEn;
  logic       w_divWr;
  logic       w_timaWr;
  logic       w_tmaWr;
  logic       w_tacWr;
  logic [2:0] w_tacNext;
  logic [7:0] w_tmaNext;
  logic [7:0] w_div;
  logic       w_tickFall;

  assign w_wrEn    = sel_tim & wr;
  assign w_divWr   = w_wrEn & (adr == ADR_DIV);
  assign w_timaWr  = w_wrEn & (adr == ADR_TIMA);
  assign w_tmaWr   = w_wrEn & (adr == ADR_TMA);
  assign w_tacWr   = w_wrEn & (adr == ADR_TAC);
  assign w_tacNext = w_tacWr ? din[2:0] : r_tac;
  assign w_tmaNext = w_tmaWr ? din : r_tma;

  gb_timer_div u_div (
    .clk        (clk),
    .reset      (reset),
    .i_divClear (w_divWr),
    .i_tacNext  (w_tacNext),
    .o_div      (w_div),
    .o_tickFall (w_tickFall)
  );

  // The reload edge takes priority over a TIMA write; a same-edge TMA write feeds the reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tima   <= 8'h00;
      r_tma    <= 8'h00;
      r_tac    <= 3'b000;
      r_state  <= ST_IDLE;
      r_ovfCnt <= 2'd0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_tmaWr) r_tma <= din;
      if (w_tacWr) r_tac <= din[2:0];
      case (r_state)
        ST_OVF: begin
          if (r_ovfCnt == OVF_LAST) begin
            r_tima  <= w_tmaNext;
            r_irq   <= 1'b1;
            r_state <= ST_RELOAD;
          end else if (w_timaWr) begin
            r_tima  <= din;
            r_state <= ST_IDLE;
          end else begin
            r_ovfCnt <= r_ovfCnt + 2'd1;
            if (w_tickFall) r_tima <= r_tima + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          if (w_timaWr) begin
            r_tima <= din;
          end else if (w_tickFall) begin
            if (r_tima == 8'hFF) begin
              r_tima   <= 8'h00;
              r_state  <= ST_OVF;
              r_ovfCnt <= 2'd0;
            end else begin
              r_tima <= r_tima + 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    dout = 8'hFF;
    if (sel_tim) begin
      case (adr)
        ADR_DIV:  dout = w_div;
        ADR_TIMA: dout = r_tima;
        ADR_TMA:  dout = r_tma;
        default:  dout = {5'b11111, r_tac};
      endcase
    end
  end

  assign irq_tim = r_irq;

endmodule

// File: tb/tb_gb_timer.sv
// Directed self-checking bench for gb_timer; edge numbers count rising clocks after reset release.
module tb_gb_timer;

  logic       clk;
  logic       reset;
  logic [1:0] adr;
  logic       sel_tim;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_tim;

  int checks = 0;
  int errors = 0;

  gb_timer dut (
    .clk     (clk),
    .reset   (reset),
    .adr     (adr),
    .sel_tim (sel_tim),
    .wr      (wr),
    .din     (din),
    .dout    (dout),
    .irq_tim (irq_tim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkReg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    adr = a;
    #1;
    checkOutput(tag, dout, exp);
  endtask

  task automatic checkIrq(input string tag, input logic exp);
    checkOutput(tag, {7'b0, irq_tim}, {7'b0, exp});
  endtask

  // One bus write cycle, returning 1 time unit after the write edge
  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
    sel_tim = 1'b1;
    adr     = a;
    din     = d;
    wr      = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic doReset();
    wr      = 1'b0;
    sel_tim = 1'b1;
    reset   = 1'b1;
    waitClk(2);
    reset = 1'b0;
  endtask

  // Leaves the bench just after edge 16, where TIMA wraps 0xFF->0x00
  task automatic startOverflow(input logic [7:0] tma);
    doReset();
    applyStimulus(2'd2, tma);
    applyStimulus(2'd1, 8'hFF);
    applyStimulus(2'd3, 8'h05);
    waitClk(12);
    checkReg("ovf_pre_tima", 2'd1, 8'hFF);
    waitClk(1);
  endtask

  initial begin
    reset   = 1'b1;
    adr     = 2'd0;
    sel_tim = 1'b1;
    wr      = 1'b0;
    din     = 8'h00;
    #3;
    checkReg("rst_div", 2'd0, 8'h00);
    checkReg("rst_tima", 2'd1, 8'h00);
    checkReg("rst_tma", 2'd2, 8'h00);
    checkReg("rst_tac", 2'd3, 8'hF8);
    checkIrq("rst_irq", 1'b0);

    // Input clock/16 counting
    doReset();
    applyStimulus(2'd3, 8'h05);
    waitClk(14);
    checkReg("cnt16_edge15", 2'd1, 8'h00);
    waitClk(1);
    checkReg("cnt16_edge16", 2'd1, 8'h01);
    waitClk(143);
    checkReg("cnt16_edge159", 2'd1, 8'h09);
    waitClk(1);
    checkReg("cnt16_edge160", 2'd1, 8'h0A);

    // Overflow: four cycles of 0x00, then TMA reload with a one-cycle irq
    startOverflow(8'hAB);
    for (int i = 0; i < 4; i++) begin
      checkReg("ovf_zero_tima", 2'd1, 8'h00);
      checkIrq("ovf_zero_irq", 1'b0);
      if (i < 3) waitClk(1);
    end
    waitClk(1);
    checkReg("ovf_reload_tima", 2'd1, 8'hAB);
    checkIrq("ovf_reload_irq", 1'b1);
    waitClk(1);
    checkIrq("ovf_after_irq", 1'b0);
    checkReg("ovf_after_tima", 2'd1, 8'hAB);

    // TIMA write during the overflow window cancels the reload
    startOverflow(8'hAB);
    waitClk(1);
    applyStimulus(2'd1, 8'h42);
    checkReg("cancel_tima", 2'd1, 8'h42);
    for (int i = 0; i < 6; i++) begin
      waitClk(1);
      checkIrq("cancel_irq", 1'b0);
    end
    checkReg("cancel_tima_late", 2'd1, 8'h42);

    // TMA written on the reload edge is the value loaded
    startOverflow(8'hAB);
    waitClk(3);
    applyStimulus(2'd2, 8'h3C);
    checkReg("tma_reload_tima", 2'd1, 8'h3C);
    checkIrq("tma_reload_irq", 1'b1);

    // TIMA written on the reload edge is ignored
    startOverflow(8'hAB);
    waitClk(3);
    applyStimulus(2'd1, 8'h99);
    checkReg("tima_reload_tima", 2'd1, 8'hAB);
    checkIrq("tima_reload_irq", 1'b1);

    // Reset in the overflow window drops the pending reload
    startOverflow(8'hAB);
    waitClk(2);
    reset = 1'b1;
    checkReg("rst_ovf_tima", 2'd1, 8'h00);
    waitClk(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      waitClk(1);
      checkIrq("rst_ovf_irq", 1'b0);
    end
    checkReg("rst_ovf_tima_late", 2'd1, 8'h00);

    // DIV write while the cnt[9] tap is high produces a tick
    doReset();
    applyStimulus(2'd3, 8'h04);
    waitClk(599);
    checkReg("divclr_div_pre", 2'd0, 8'h02);
    checkReg("divclr_tima_pre", 2'd1, 8'h00);
    applyStimulus(2'd0, 8'h77);
    checkReg("divclr_tima", 2'd1, 8'h01);
    checkReg("divclr_div", 2'd0, 8'h00);

    // Disabling TAC while the cnt[3] tap is high produces a tick
    doReset();
    applyStimulus(2'd3, 8'h05);
    waitClk(9);
    checkReg("tacclr_tima_pre", 2'd1, 8'h00);
    applyStimulus(2'd3, 8'h01);
    checkReg("tacclr_tima", 2'd1, 8'h01);
    checkReg("tacclr_tac", 2'd3, 8'hF9);
    waitClk(20);
    checkReg("tacclr_tima_hold", 2'd1, 8'h01);

    // Writes with sel_tim low are ignored and reads return 0xFF
    waitClk(300);
    checkReg("nosel_div_pre", 2'd0, 8'h01);
    sel_tim = 1'b0;
    wr      = 1'b1;
    din     = 8'h55;
    for (int a = 0; a < 4; a++) begin
      adr = 2'(a);
      #1;
      checkOutput("nosel_dout", dout, 8'hFF);
      @(posedge clk);
      #1;
    end
    wr      = 1'b0;
    sel_tim = 1'b1;
    checkReg("nosel_div", 2'd0, 8'h01);
    checkReg("nosel_tima", 2'd1, 8'h01);
    checkReg("nosel_tma", 2'd2, 8'h00);
    checkReg("nosel_tac", 2'd3, 8'hF9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_timer.md
GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL expose: clk  in  1  system clock, 4.194304 MHz T-cycle rate.
REQ-003 SHALL expose: reset  in  1  asynchronous active-high reset.
REQ-004 SHALL expose: adr  in  2  register offset, low bits of I/O address (0=DIV FF04, 1=TIMA FF05, 2=TMA FF06, 3=TAC FF07).
REQ-005 SHALL expose: sel_tim  in  1  timer select from the I/O address decoder.
REQ-006 SHALL expose: wr  in  1  bus write strobe, sampled at rising clk.
REQ-007 SHALL expose: din  in  8  write data.
REQ-008 SHALL expose: dout  out  8  read data, combinational.
REQ-009 SHALL expose: irq_tim  out  1  one-clk timer interrupt request pulse toward IF.

Function
REQ-010 SHALL hold a 16-bit free-running counter cnt, incremented by 1 every clk, wrapping 0xFFFF->0x0000.
REQ-011 DIV read SHALL return cnt[15:8].
REQ-012 A write to DIV (sel_tim & wr & adr=0) SHALL clear cnt to 0 at that edge, regardless of din.
REQ-013 Tap bit: TAC[1:0]=00 -> cnt[9], 01 -> cnt[3], 10 -> cnt[5], 11 -> cnt[7].
REQ-014 Tick signal = TAC[2] AND selected tap bit; TIMA SHALL increment once on every 1->0 transition of tick, including transitions caused by DIV clear, TAC enable clear, or TAC select change.
REQ-015 TIMA increment 0xFF->0x00 SHALL start overflow state: TIMA reads 0x00 for 4 clk, then at the 4th edge TIMA loads TMA and irq_tim is high for exactly that following clk.
REQ-016 Overflow states: IDLE -> OVF (counts 4 clk) -> RELOAD (1 clk: TIMA=TMA, irq_tim=1) -> IDLE.
REQ-017 A TIMA write during OVF SHALL store din and cancel the pending reload and interrupt.
REQ-018 A TIMA write during the RELOAD edge SHALL be ignored; TIMA takes TMA.
REQ-019 A TMA write coinciding with the reload edge SHALL make TIMA load the newly written TMA value.
REQ-020 Ticks during OVF SHALL increment the 0x00 value normally; the reload still overwrites it.
REQ-021 TMA and TAC writes SHALL take effect at the write edge; TAC stores din[2:0].
REQ-022 Reads: TIMA and TMA return stored values; TAC returns {5'b11111, TAC[2:0]}.
REQ-023 dout SHALL be 0xFF whenever sel_tim is low.
REQ-024 Writes with sel_tim low SHALL have no effect.

Reset
REQ-025 On reset: cnt=0, TIMA=0, TMA=0, TAC=0, overflow state IDLE, tick history 0, irq_tim=0.
REQ-026 Reset asserted during OVF SHALL cancel the reload; no irq_tim after release.
REQ-027 First increment of cnt SHALL occur at the first rising clk after reset deasserts.

Structure
REQ-028 Register offsets (DIV/TIMA/TMA/TAC), the TAC tap table and the overflow delay (4) SHALL live in the shared gb package/include as named constants.
REQ-029 A sub-module gb_timer_div SHALL contain cnt, the DIV clear, tap mux and falling-edge tick detect; gb_timer holds TIMA/TMA/TAC, the overflow FSM and bus mux.

Verification
REQ-030 Reset, TAC=0x05, TIMA=0x00: after 16 clk TIMA=0x01, after 160 clk TIMA=0x0A.
REQ-031 TMA=0xAB, TIMA=0xFF, TAC=0x05: on overflow TIMA reads 0x00 for 4 clk, then 0xAB, irq_tim high exactly 1 clk.
REQ-032 Same setup, write TIMA=0x42 2 clk after overflow: TIMA=0x42, no irq_tim, no reload.
REQ-033 TAC=0x04, cnt[9]=1: DIV write -> TIMA increments by 1 and DIV reads 0x00 next clk.
REQ-034 TAC=0x05 with cnt[3]=1, write TAC=0x01 -> TIMA increments once; read TAC -> 0xF9.
REQ-035 sel_tim=0 with wr=1, din=0x55: no register changes and dout=0xFF.
